// File: rtl/switch_input_ctrl.sv
// switch_input_ctrl: memory-mapped input port for board slide switches and
// push-buttons. Inputs are synchronised, buttons are debounced, and button
// press edges are kept as sticky flags until software reads them.
module switch_input_ctrl #(
    parameter int unsigned SW_WIDTH        = 24,
    parameter int unsigned BTN_COUNT       = 2,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  SwitchCtrl,
    input  logic                  ioRead,
    input  logic [2:0]            switchAddr,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic [BTN_COUNT-1:0]  buttons,
    output logic [DATA_WIDTH-1:0] input_data,
    output logic                  rd_valid,
    output logic [BTN_COUNT-1:0]  btn_level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        REG_SW_LOW   = 3'd0,
        REG_SW_BYTE0 = 3'd1,
        REG_SW_BYTE2 = 3'd2,
        REG_EDGE     = 3'd3,
        REG_LEVEL    = 3'd4,
        REG_OVF      = 3'd5,
        REG_RSVD6    = 3'd6,
        REG_RSVD7    = 3'd7
    } reg_sel_e;

    logic [SW_WIDTH-1:0]   sw_meta;
    logic [SW_WIDTH-1:0]   sw_sync;
    logic [BTN_COUNT-1:0]  btn_meta;
    logic [BTN_COUNT-1:0]  btn_sync;

    logic [CNT_W-1:0]      cnt_q [BTN_COUNT];
    logic [CNT_W-1:0]      cnt_d [BTN_COUNT];
    logic [BTN_COUNT-1:0]  level_q;
    logic [BTN_COUNT-1:0]  level_d;
    logic [BTN_COUNT-1:0]  rise;
    logic [BTN_COUNT-1:0]  edge_q;
    logic [BTN_COUNT-1:0]  edge_d;
    logic [BTN_COUNT-1:0]  ovf_q;
    logic [BTN_COUNT-1:0]  ovf_d;

    logic                  rd_req;
    reg_sel_e              rd_sel;
    logic                  clr_edge;
    logic                  clr_ovf;
    logic [DATA_WIDTH-1:0] rd_mux;

    assign btn_level = level_q;
    assign rd_req    = SwitchCtrl && ioRead;
    assign rd_sel    = reg_sel_e'(switchAddr);
    assign clr_edge  = rd_req && (rd_sel == REG_EDGE);
    assign clr_ovf   = rd_req && (rd_sel == REG_OVF);

    // Two-flop synchronisers for all asynchronous pins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= switches;
            sw_sync  <= sw_meta;
            btn_meta <= buttons;
            btn_sync <= btn_meta;
        end
    end

    // Debounce counters, accepted levels and sticky edge/overflow flags (next state).
    always_comb begin
        level_d = level_q;
        for (int unsigned i = 0; i < BTN_COUNT; i++) begin
            cnt_d[i] = '0;
            if (btn_sync[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise   = level_d & ~level_q;
        // A rising edge in the same cycle as a clearing read keeps the flag set.
        edge_d = (edge_q & ~{BTN_COUNT{clr_edge}}) | rise;
        ovf_d  = (ovf_q & ~{BTN_COUNT{clr_ovf}}) | (rise & edge_q);
    end

    // Debounce and flag state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < BTN_COUNT; i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= '0;
            edge_q  <= '0;
            ovf_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < BTN_COUNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q <= level_d;
            edge_q  <= edge_d;
            ovf_q   <= ovf_d;
        end
    end

    // Register-select mux; flags are returned before any clear takes effect.
    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            REG_SW_LOW:   rd_mux = DATA_WIDTH'(sw_sync);
            REG_SW_BYTE0: rd_mux = DATA_WIDTH'(sw_sync[7:0]);
            REG_SW_BYTE2: rd_mux = DATA_WIDTH'(sw_sync[23:16]);
            REG_EDGE:     rd_mux = DATA_WIDTH'(edge_q);
            REG_LEVEL:    rd_mux = DATA_WIDTH'(level_q);
            REG_OVF:      rd_mux = DATA_WIDTH'(ovf_q);
            REG_RSVD6:    rd_mux = '0;
            REG_RSVD7:    rd_mux = '0;
            default:      rd_mux = '0;
        endcase
    end

    // Read data register and one-cycle valid pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            input_data <= '0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                input_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_switch_input_ctrl.sv
// tb_switch_input_ctrl: directed bench for switch_input_ctrl with default
// parameters (24 switches, 2 buttons, 16-bit bus, 4-cycle debounce).
module tb_switch_input_ctrl;

    logic        clock;
    logic        reset;
    logic        SwitchCtrl;
    logic        ioRead;
    logic [2:0]  switchAddr;
    logic [23:0] switches;
    logic [1:0]  buttons;
    logic [15:0] input_data;
    logic        rd_valid;
    logic [1:0]  btn_level;

    int total;
    int bad;

    switch_input_ctrl #(
        .SW_WIDTH(24),
        .BTN_COUNT(2),
        .DATA_WIDTH(16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .SwitchCtrl(SwitchCtrl),
        .ioRead(ioRead),
        .switchAddr(switchAddr),
        .switches(switches),
        .buttons(buttons),
        .input_data(input_data),
        .rd_valid(rd_valid),
        .btn_level(btn_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single read: strobe for one cycle, check data and the valid pulse.
    task automatic do_read(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        SwitchCtrl = 1'b1;
        ioRead     = 1'b1;
        switchAddr = addr;
        tick();
        SwitchCtrl = 1'b0;
        ioRead     = 1'b0;
        chk(tag, {16'h0, input_data}, {16'h0, exp});
        chk({tag, "_valid"}, {31'h0, rd_valid}, 32'h1);
        tick();
        chk({tag, "_valid_off"}, {31'h0, rd_valid}, 32'h0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        SwitchCtrl = 1'b0;
        ioRead     = 1'b0;
        switchAddr = 3'd0;
        switches   = 24'h0;
        buttons    = 2'b00;

        // Reset state
        ticks(2);
        chk("rst_data", {16'h0, input_data}, 32'h0);
        chk("rst_valid", {31'h0, rd_valid}, 32'h0);
        chk("rst_level", {30'h0, btn_level}, 32'h0);
        reset = 1'b1;
        tick();

        // 1. switch reads
        switches = 24'hA5C3F0;
        ticks(3);
        do_read("sw_addr0", 3'd0, 16'hC3F0);
        do_read("sw_addr1", 3'd1, 16'h00F0);
        do_read("sw_addr2", 3'd2, 16'h00A5);
        do_read("sw_addr6", 3'd6, 16'h0000);
        do_read("sw_addr7", 3'd7, 16'h0000);
        // no read: data holds
        tick();
        chk("hold_data", {16'h0, input_data}, 32'h0);
        // back-to-back reads
        SwitchCtrl = 1'b1;
        ioRead     = 1'b1;
        switchAddr = 3'd0;
        tick();
        chk("b2b_first", {16'h0, input_data}, 32'hC3F0);
        chk("b2b_first_valid", {31'h0, rd_valid}, 32'h1);
        switchAddr = 3'd1;
        tick();
        SwitchCtrl = 1'b0;
        ioRead     = 1'b0;
        chk("b2b_second", {16'h0, input_data}, 32'h00F0);
        chk("b2b_second_valid", {31'h0, rd_valid}, 32'h1);
        tick();
        chk("b2b_valid_off", {31'h0, rd_valid}, 32'h0);
        chk("b2b_hold", {16'h0, input_data}, 32'h00F0);

        // 2. bounce 1-0-1 (2-cycle pulses), then hold 1
        buttons[0] = 1'b1;
        ticks(2);
        buttons[0] = 1'b0;
        ticks(2);
        buttons[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("bounce_lvl_%0d", k), {30'h0, btn_level}, 32'h0);
        end
        tick();
        chk("bounce_lvl_6", {30'h0, btn_level}, 32'h1);
        ticks(3);
        chk("bounce_lvl_stable", {30'h0, btn_level}, 32'h1);

        // 3. edge flag read and clear
        do_read("edge_once", 3'd3, 16'h0001);
        do_read("edge_cleared", 3'd3, 16'h0000);
        do_read("ovf_none", 3'd5, 16'h0000);
        do_read("level_b0", 3'd4, 16'h0001);

        // 4. btn1 pressed twice without reading
        for (int p = 0; p < 2; p++) begin
            buttons[1] = 1'b1;
            ticks(8);
            buttons[1] = 1'b0;
            ticks(8);
        end
        do_read("ovf_b1", 3'd5, 16'h0002);
        do_read("ovf_b1_cleared", 3'd5, 16'h0000);
        do_read("edge_b1", 3'd3, 16'h0002);
        do_read("edge_b1_cleared", 3'd3, 16'h0000);

        // 5. btn0 edge in the same cycle as an addr 3 read
        buttons[0] = 1'b0;
        ticks(10);
        chk("b0_released", {30'h0, btn_level}, 32'h0);
        buttons[0] = 1'b1;
        ticks(5);
        chk("coll_pre_level", {30'h0, btn_level}, 32'h0);
        SwitchCtrl = 1'b1;
        ioRead     = 1'b1;
        switchAddr = 3'd3;
        tick();
        SwitchCtrl = 1'b0;
        ioRead     = 1'b0;
        chk("coll_level", {30'h0, btn_level}, 32'h1);
        chk("coll_read", {16'h0, input_data}, 32'h0);
        tick();
        do_read("coll_next", 3'd3, 16'h0001);
        do_read("coll_cleared", 3'd3, 16'h0000);

        // 6. reset mid-debounce and mid-read
        buttons[0] = 1'b0;
        ticks(10);
        buttons[0] = 1'b1;
        ticks(3);
        SwitchCtrl = 1'b1;
        ioRead     = 1'b1;
        switchAddr = 3'd0;
        tick();
        chk("pre_rst_data", {16'h0, input_data}, 32'hC3F0);
        chk("pre_rst_valid", {31'h0, rd_valid}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_data", {16'h0, input_data}, 32'h0);
        chk("async_rst_valid", {31'h0, rd_valid}, 32'h0);
        chk("async_rst_level", {30'h0, btn_level}, 32'h0);
        SwitchCtrl = 1'b0;
        ioRead     = 1'b0;
        ticks(3);
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("post_rst_lvl_%0d", k), {30'h0, btn_level}, 32'h0);
        end
        tick();
        chk("post_rst_lvl_6", {30'h0, btn_level}, 32'h1);
        do_read("post_rst_edge", 3'd3, 16'h0001);
        do_read("post_rst_ovf", 3'd5, 16'h0000);
        do_read("post_rst_edge_clr", 3'd3, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
